lsu_sram_if: RTL and testbench

- Load/store unit for the MEM stage of the LoongArch pipeline.
- Takes the effective address computed by the execute-stage ALU, plus the store data and the access op.
- Drives an SRAM-like data-memory interface (req/addr_ok/data_ok) with byte strobes and lane-replicated write data.
- Returns load data, byte-aligned and sign/zero-extended, to writeback.
- One transaction outstanding at a time.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_load_ext.sv | 27 ++
 rtl/lsu_sram_if.sv | 160 ++++++++++++++++
 tb/tb_lsu_sram_if.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the LoongArch MEM-stage load/store unit: op-field bit
// positions, access-size codes, FSM states and small decode helpers.
package lsu_pkg;

    localparam int OP_STORE = 3;
    localparam int OP_UNS   = 2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // Size code 3 is treated as a word everywhere downstream.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_W : sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    return lo[0];
            SZ_W:    return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-lane select and sign/zero extension for the LSU.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        ext_o = rdata_i;
        case (size_i)
            SZ_B:    ext_o = {{24{~uns_i & byte_lane[7]}}, byte_lane};
            SZ_H:    ext_o = {{16{~uns_i & half_lane[15]}}, half_lane};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_sram_if.sv
// MEM-stage load/store unit driving an SRAM-like req/addr_ok/data_ok port.
// Optional misaligned-address exception check: define LSU_ALE_CHECK_EN.
//
// state  | meaning
// IDLE   | ready for a new access from EX
// REQ    | data_sram_req high, waiting for addr_ok
// WAIT   | address accepted, waiting for data_ok
// RESP   | result presented to writeback until out_ready
module lsu_sram_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [DEST_W-1:0] in_dest,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_ale
);

    lsu_state_e        state_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [DEST_W-1:0] dest_q;
    logic              req_q;
    logic              out_valid_q;
    logic [31:0]       out_data_q;
    logic [1:0]        size_n;
    logic [3:0]        strb;
    logic [31:0]       load_ext;

    assign size_n = norm_size(op_q[1:0]);

    lsu_load_ext u_load_ext (
        .rdata_i   (data_sram_rdata),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_n),
        .uns_i     (op_q[OP_UNS]),
        .ext_o     (load_ext)
    );

`ifdef LSU_ALE_CHECK_EN
    logic        out_ale_q;
    logic        ale_hit;
    logic [31:0] badv;
    assign ale_hit = misaligned(norm_size(in_op[1:0]), in_addr[1:0]);
    assign badv    = 32'(in_addr);
    assign out_ale = out_ale_q;
`else
    assign out_ale = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dest_q      <= '0;
            req_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef LSU_ALE_CHECK_EN
            out_ale_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        addr_q  <= in_addr;
                        wdata_q <= in_wdata;
                        dest_q  <= in_dest;
`ifdef LSU_ALE_CHECK_EN
                        out_ale_q <= ale_hit;
                        if (ale_hit) begin
                            // Misaligned: skip memory, report the address as BADV.
                            state_q     <= S_RESP;
                            out_valid_q <= 1'b1;
                            out_data_q  <= badv;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end
`else
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
`endif
                    end
                end
                S_REQ: begin
                    if (data_sram_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_sram_data_ok) begin
                        state_q     <= S_RESP;
                        out_valid_q <= 1'b1;
                        out_data_q  <= op_q[OP_STORE] ? 32'd0 : load_ext;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        strb            = 4'b1111;
        data_sram_wdata = wdata_q;
        case (size_n)
            SZ_B: begin
                strb            = 4'b0001 << addr_q[1:0];
                data_sram_wdata = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                strb            = 4'b0011 << {addr_q[1], 1'b0};
                data_sram_wdata = {2{wdata_q[15:0]}};
            end
            default: strb = 4'b1111;
        endcase
    end

    assign in_ready        = (state_q == S_IDLE);
    assign data_sram_req   = req_q;
    assign data_sram_wr    = op_q[OP_STORE];
    assign data_sram_size  = size_n;
    assign data_sram_addr  = addr_q;
    assign data_sram_wstrb = op_q[OP_STORE] ? strb : 4'b0000;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_dest        = dest_q;

endmodule

// File: tb/tb_lsu_sram_if.sv
// Scoreboard bench for lsu_sram_if: directed plus random accesses against a
// byte-level reference model, a scripted SRAM responder and a result monitor.
module tb_lsu_sram_if;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_dest;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic        out_ale;

    // Memory side is either scripted by the responder or driven by hand.
    bit          auto_mem;
    logic        mem_aok, mem_dok, man_aok, man_dok;
    logic [31:0] mem_rdata, man_rdata;
    assign data_sram_addr_ok = auto_mem ? mem_aok   : man_aok;
    assign data_sram_data_ok = auto_mem ? mem_dok   : man_dok;
    assign data_sram_rdata   = auto_mem ? mem_rdata : man_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aok;
        int          dok;
        bit          sticky;
        bit          junk;
    } mem_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        ale;
        int          ordy;
    } res_t;

    mem_t mem_q[$];
    res_t res_q[$];

    lsu_sram_if #(.ADDR_W(32), .DEST_W(5)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_op             (in_op),
        .in_addr           (in_addr),
        .in_wdata          (in_wdata),
        .in_dest           (in_dest),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_dest          (out_dest),
        .out_ale           (out_ale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: treats the access as n bytes starting at byte offset off.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int aok, input int dok, input int ordy,
                         input bit sticky, input bit junk);
        int          n, off, lo;
        bit          mis, ale_en, accepted;
        logic [31:0] val, wd;
        logic [3:0]  ws;
        logic [4:0]  dest;
        mem_t        m;
        res_t        r;
        n   = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        lo  = int'(addr[1:0]);
        off = (lo / n) * n;
        mis = (lo % n) != 0;
`ifdef LSU_ALE_CHECK_EN
        ale_en = 1'b1;
`else
        ale_en = 1'b0;
`endif
        ws = 4'b0000;
        wd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (op[3] && i >= off && i < off + n) ws[i] = 1'b1;
            wd[8*i +: 8] = wdata[8*(i % n) +: 8];
        end
        val = 32'd0;
        for (int k = 0; k < n; k++)
            val = val + ({24'd0, rdata[8*(off+k) +: 8]} << (8*k));
        if (!op[2] && n < 4 && val >= (32'd1 << (8*n - 1)))
            val = val - (32'd1 << (8*n));
        dest = 5'($urandom);
        if (ale_en && mis) begin
            r = '{data: addr, dest: dest, ale: 1'b1, ordy: ordy};
        end else begin
            m = '{addr: addr, wr: op[3], size: (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2,
                  wstrb: ws, wdata: wd, rdata: rdata, aok: aok, dok: dok,
                  sticky: sticky, junk: junk};
            mem_q.push_back(m);
            r = '{data: op[3] ? 32'd0 : val, dest: dest, ale: 1'b0, ordy: ordy};
        end
        res_q.push_back(r);
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        in_dest  = dest;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int w = 0; w < 200 && !accepted; w++) begin
            if (in_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        chkb("accept_timeout", accepted, 1'b1);
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_addr  = $urandom;
        in_wdata = $urandom;
        in_dest  = 5'($urandom);
    endtask

    // SRAM responder
    initial begin
        mem_t m;
        mem_aok   = 1'b0;
        mem_dok   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (auto_mem && resetn && data_sram_req) begin
                if (mem_q.size() == 0) begin
                    chkb("unexpected_req", data_sram_req, 1'b0);
                    mem_aok = 1'b1; @(posedge clk); #1; mem_aok = 1'b0;
                    mem_dok = 1'b1; @(posedge clk); #1; mem_dok = 1'b0;
                end else begin
                    m = mem_q.pop_front();
                    chk("req_addr", data_sram_addr, m.addr);
                    chkb("req_wr", data_sram_wr, m.wr);
                    chk("req_size", 32'(data_sram_size), 32'(m.size));
                    chk("req_wstrb", 32'(data_sram_wstrb), 32'(m.wstrb));
                    if (m.wr) chk("req_wdata", data_sram_wdata, m.wdata);
                    for (int i = 0; i < m.aok; i++) begin
                        if (m.junk && i == 0) begin
                            mem_dok   = 1'b1;
                            mem_rdata = $urandom;
                        end
                        @(posedge clk); #1;
                        mem_dok = 1'b0;
                        chkb("req_held", data_sram_req, 1'b1);
                        chk("addr_held", data_sram_addr, m.addr);
                        chk("wstrb_held", 32'(data_sram_wstrb), 32'(m.wstrb));
                    end
                    mem_aok = 1'b1;
                    @(posedge clk); #1;
                    if (!m.sticky) mem_aok = 1'b0;
                    chkb("req_drop", data_sram_req, 1'b0);
                    repeat (m.dok) begin
                        @(posedge clk); #1;
                    end
                    mem_dok   = 1'b1;
                    mem_rdata = m.rdata;
                    @(posedge clk); #1;
                    mem_dok   = 1'b0;
                    mem_aok   = 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Result monitor
    initial begin
        res_t r;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (resetn && out_valid) begin
                if (res_q.size() == 0) begin
                    chkb("unexpected_out_valid", out_valid, 1'b0);
                    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
                end else begin
                    r = res_q.pop_front();
                    chk("out_data", out_data, r.data);
                    chk("out_dest", 32'(out_dest), 32'(r.dest));
                    chkb("out_ale", out_ale, r.ale);
                    for (int i = 0; i < r.ordy; i++) begin
                        @(posedge clk); #1;
                        chkb("hold_valid", out_valid, 1'b1);
                        chk("hold_data", out_data, r.data);
                        chkb("hold_in_ready", in_ready, 1'b0);
                    end
                    out_ready = 1'b1;
                    @(posedge clk); #1;
                    out_ready = 1'b0;
                    chkb("valid_drop", out_valid, 1'b0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        resetn    = 1'b0;
        auto_mem  = 1'b1;
        man_aok   = 1'b0;
        man_dok   = 1'b0;
        man_rdata = 32'd0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_addr   = 32'd0;
        in_wdata  = 32'd0;
        in_dest   = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_req", data_sram_req, 1'b0);
        chkb("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_dest", 32'(out_dest), 32'd0);
        chkb("rst_out_ale", out_ale, 1'b0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Stale data_ok while idle must not produce a result.
        auto_mem  = 1'b0;
        man_dok   = 1'b1;
        man_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        man_dok = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chkb("stale_dok_valid", out_valid, 1'b0);
            chkb("stale_dok_ready", in_ready, 1'b1);
        end
        auto_mem = 1'b1;

        issue(4'b1000, 32'h0000_1003, 32'h0000_00A5, 32'h0,         0, 0, 0, 0, 0);
        issue(4'b0000, 32'h0000_1002, $urandom,      32'h1280_3456, 0, 0, 0, 0, 0);
        issue(4'b0100, 32'h0000_1002, $urandom,      32'h1280_3456, 0, 1, 0, 0, 0);
        issue(4'b0001, 32'h0000_2002, $urandom,      32'h8001_FFFF, 0, 0, 0, 0, 0);
        issue(4'b0010, 32'h0000_2000, $urandom,      32'h8001_FFFF, 0, 0, 0, 0, 0);
        issue(4'b1001, 32'h0000_4002, 32'h1234_BEEF, 32'h0,         3, 1, 2, 1, 1);
        issue(4'b0010, 32'h0000_3001, $urandom,      32'hCAFE_F00D, 1, 0, 1, 0, 0);
        issue(4'b0011, 32'h0000_5004, $urandom,      32'h89AB_CDEF, 0, 2, 0, 0, 0);
        issue(4'b1011, 32'h0000_5008, 32'h7654_3210, 32'h0,         2, 0, 1, 0, 1);

        for (int i = 0; i < 200; i++)
            issue(4'($urandom), $urandom, $urandom, $urandom,
                  int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                  int'($urandom_range(2, 0)), bit'($urandom_range(1, 0)),
                  bit'($urandom_range(1, 0)));

        w = 0;
        while ((res_q.size() != 0 || mem_q.size() != 0 || out_valid || !in_ready) && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        chkb("drain_done", w < 2000, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while waiting for data_ok.
        auto_mem = 1'b0;
        in_op    = 4'b0000;
        in_addr  = 32'h0000_6001;
        in_wdata = 32'd0;
        in_dest  = 5'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chkb("rst_test_req_up", data_sram_req, 1'b1);
        chk("rst_test_dest", 32'(out_dest), 32'd7);
        man_aok = 1'b1;
        @(posedge clk); #1;
        man_aok = 1'b0;
        chkb("rst_test_in_wait_req", data_sram_req, 1'b0);
        chkb("rst_test_in_wait_ready", in_ready, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chkb("midrst_req", data_sram_req, 1'b0);
        chkb("midrst_in_ready", in_ready, 1'b1);
        chkb("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_addr", data_sram_addr, 32'd0);
        chk("midrst_out_dest", 32'(out_dest), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        man_dok   = 1'b1;
        man_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        man_dok = 1'b0;
        repeat (3) begin
            chkb("post_rst_no_valid", out_valid, 1'b0);
            chkb("post_rst_ready", in_ready, 1'b1);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
